// File: rtl/spi_master_param.sv
// Wishbone-attached SPI master: one byte per DATA write, programmable divider,
// CPOL/CPHA/bit-order and a directly driven bank of active-low slave selects.
module spi_master_param #(
    parameter int          NUM_SS  = 8,
    parameter logic [7:0]  DIV_RST = 8'd1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [1:0]        wb_adr_i,
    input  logic [15:0]       wb_dat_i,
    output logic [15:0]       wb_dat_o,
    input  logic              wb_we_i,
    input  logic [1:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    output logic              sclk,
    input  logic              miso,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss
);

    // state   | meaning
    // IDLE    | no transfer; register accesses only
    // XFER    | shifting one byte, 16 sclk edges
    // DONE    | byte captured, completion ack issued on exit
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_CTRL   = 2'd1;
    localparam logic [1:0] ADR_SS     = 2'd2;
    localparam logic [1:0] ADR_STATUS = 2'd3;

    logic [1:0]        r_state;
    logic [10:0]       r_ctrl;
    logic [NUM_SS-1:0] r_ss;
    logic              r_ack;
    logic [15:0]       r_dat_o;
    logic [7:0]        r_rx_byte;
    logic              r_sclk;
    logic              r_mosi;
    logic [7:0]        r_tx;
    logic [7:0]        r_rx;
    logic [7:0]        r_div;
    logic              r_cpha;
    logic              r_lsbf;
    logic [7:0]        r_div_cnt;
    logic [4:0]        r_edge_cnt;

    logic        w_req;
    logic        w_data_wr;
    logic        w_start;
    logic        w_acc;
    logic        w_done_ack;
    logic        w_busy;
    logic        w_tick;
    logic [4:0]  w_edge_num;
    logic        w_odd;
    logic        w_sample;
    logic        w_shift;
    logic        w_last;
    logic [7:0]  w_rx_next;
    logic        w_ss_sel;
    logic [15:0] w_rd_data;
    logic        w_unused;

    assign w_req     = wb_stb_i & wb_cyc_i;
    assign w_data_wr = w_req & wb_we_i & (wb_adr_i == ADR_DATA);
    assign w_busy    = (r_state != ST_IDLE);

    // A DATA write is held on the bus for the whole byte, so outside IDLE it
    // is the pending transfer and must not be acked as an ordinary access.
    assign w_start    = (r_state == ST_IDLE) & w_data_wr & wb_sel_i[0] & ~r_ack;
    assign w_acc      = w_req & ~r_ack &
                        ((r_state == ST_IDLE) ? ~(w_data_wr & wb_sel_i[0]) : ~w_data_wr);
    assign w_done_ack = (r_state == ST_DONE) & w_data_wr;

    assign w_ss_sel = wb_sel_i[0] & ((NUM_SS > 8) ? wb_sel_i[1] : 1'b1);

    assign w_tick     = (r_state == ST_XFER) & (r_div_cnt == 8'd0);
    assign w_edge_num = r_edge_cnt + 5'd1;
    assign w_odd      = ~r_edge_cnt[0];
    assign w_sample   = w_tick & (r_cpha ? ~w_odd : w_odd);
    assign w_shift    = w_tick & (r_cpha ? w_odd : (~w_odd & (w_edge_num != 5'd16)));
    assign w_last     = w_tick & (r_edge_cnt == 5'd15);
    assign w_rx_next  = w_sample ? (r_lsbf ? {miso, r_rx[7:1]} : {r_rx[6:0], miso}) : r_rx;

    assign w_unused = &{1'b0, wb_dat_i[15:11]};

    always_comb begin
        w_rd_data = 16'h0000;
        case (wb_adr_i)
            ADR_DATA:   w_rd_data = {8'h00, r_rx_byte};
            ADR_CTRL:   w_rd_data = {5'b00000, r_ctrl};
            ADR_SS:     w_rd_data[NUM_SS-1:0] = r_ss;
            ADR_STATUS: w_rd_data = {15'h0000, w_busy};
            default:    w_rd_data = 16'h0000;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= {1'b0, 1'b1, 1'b1, DIV_RST};
            r_ss       <= '1;
            r_ack      <= 1'b0;
            r_dat_o    <= 16'h0000;
            r_rx_byte  <= 8'h00;
            r_sclk     <= 1'b1;
            r_mosi     <= 1'b1;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_div      <= 8'h00;
            r_cpha     <= 1'b0;
            r_lsbf     <= 1'b0;
            r_div_cnt  <= 8'h00;
            r_edge_cnt <= 5'd0;
        end else begin
            r_ack <= w_acc | w_done_ack;

            if (w_acc & ~wb_we_i)
                r_dat_o <= w_rd_data;
            if (w_acc & wb_we_i & (wb_adr_i == ADR_CTRL) & (wb_sel_i == 2'b11))
                r_ctrl <= wb_dat_i[10:0];
            if (w_acc & wb_we_i & (wb_adr_i == ADR_SS) & w_ss_sel)
                r_ss <= wb_dat_i[NUM_SS-1:0];

            case (r_state)
                ST_IDLE: begin
                    r_sclk <= r_ctrl[8];
                    r_mosi <= 1'b1;
                    if (w_start) begin
                        r_state    <= ST_XFER;
                        r_div      <= r_ctrl[7:0];
                        r_div_cnt  <= r_ctrl[7:0];
                        r_cpha     <= r_ctrl[9];
                        r_lsbf     <= r_ctrl[10];
                        r_sclk     <= r_ctrl[8];
                        r_edge_cnt <= 5'd0;
                        r_rx       <= 8'h00;
                        // With CPHA=0 the first bit must already be on mosi
                        // half a period before the first sampling edge.
                        if (!r_ctrl[9]) begin
                            r_mosi <= r_ctrl[10] ? wb_dat_i[0] : wb_dat_i[7];
                            r_tx   <= r_ctrl[10] ? {1'b0, wb_dat_i[7:1]} : {wb_dat_i[6:0], 1'b0};
                        end else begin
                            r_tx   <= wb_dat_i[7:0];
                        end
                    end
                end
                ST_XFER: begin
                    if (w_tick) begin
                        r_div_cnt  <= r_div;
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= w_edge_num;
                        r_rx       <= w_rx_next;
                        if (w_shift) begin
                            r_mosi <= r_lsbf ? r_tx[0] : r_tx[7];
                            r_tx   <= r_lsbf ? {1'b0, r_tx[7:1]} : {r_tx[6:0], 1'b0};
                        end
                        if (w_last) begin
                            r_rx_byte <= w_rx_next;
                            r_state   <= ST_DONE;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_mosi  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wb_dat_o = r_dat_o;
    assign wb_ack_o = r_ack;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign ss       = r_ss;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: register-access vector table followed
// by hand-written transfer sequences (modes, divider, dropped cycle, reset).
module tb_spi_master_param;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [1:0]  wb_adr_i = 2'd0;
    logic [15:0] wb_dat_i = 16'h0000;
    logic [15:0] wb_dat_o;
    logic        wb_we_i  = 1'b0;
    logic [1:0]  wb_sel_i = 2'b00;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic        sclk;
    logic        miso;
    logic        mosi;
    logic [7:0]  ss;

    logic        tie_mode = 1'b0;
    logic        tie_val  = 1'b1;
    assign miso = tie_mode ? tie_val : mosi;

    int n_checks = 0;
    int n_errors = 0;

    spi_master_param #(.NUM_SS(8), .DIV_RST(8'd1)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_ack_o(wb_ack_o), .sclk(sclk), .miso(miso), .mosi(mosi), .ss(ss)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [1:0]  adr;
        logic [15:0] dat;
        logic        we;
        logic [1:0]  sel;
        logic [15:0] exp_rd;
        logic [7:0]  exp_ss;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Single access; lat counts cycles from the sampling edge to ack visible.
    task automatic wb_access(input logic [1:0] adr, input logic [15:0] dat, input logic we,
                             input logic [1:0] sel, output logic [15:0] rdata, output int lat);
        @(negedge wb_clk_i);
        wb_adr_i = adr; wb_dat_i = dat; wb_we_i = we; wb_sel_i = sel;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        lat = -1;
        rdata = 'x;
        for (int c = 0; c < 20; c++) begin
            @(posedge wb_clk_i); #1;
            if (wb_ack_o) begin
                lat = c + 1;
                rdata = wb_dat_o;
                break;
            end
        end
        @(negedge wb_clk_i);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    endtask

    // One DATA write; records edges, their spacing, mosi at sampling edges
    // (in transmission order), optional bus drop or reset at a given edge.
    task automatic xfer(input logic [7:0] data, input int div, input bit cpha,
                        input int drop_edge, input int rst_edge,
                        output int lat, output int edges, output logic [7:0] bits,
                        output bit spacing_ok, output bit rst_ok);
        logic prev_sclk;
        int   last;
        bit   rst_pend;
        @(negedge wb_clk_i);
        wb_adr_i = 2'd0; wb_dat_i = {8'h00, data}; wb_we_i = 1'b1; wb_sel_i = 2'b01;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        prev_sclk = sclk; last = 0; edges = 0; bits = 8'h00;
        spacing_ok = 1'b1; rst_ok = 1'b1; rst_pend = 1'b0; lat = -1;
        for (int c = 0; c < 16 * (div + 1) + 8; c++) begin
            @(posedge wb_clk_i); #1;
            if (rst_pend) begin
                rst_ok = (sclk === 1'b1) && (mosi === 1'b1) && (wb_ack_o === 1'b0);
                wb_rst_i = 1'b0;
                rst_pend = 1'b0;
                prev_sclk = sclk;
                continue;
            end
            if (sclk !== prev_sclk) begin
                edges++;
                if (c - last != div + 1) spacing_ok = 1'b0;
                last = c;
                if (((edges % 2) == 0) == cpha) bits = {bits[6:0], mosi};
                prev_sclk = sclk;
                if (edges == drop_edge) begin
                    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
                end
                if (edges == rst_edge) begin
                    wb_rst_i = 1'b1; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
                    rst_pend = 1'b1;
                end
            end
            if (wb_ack_o) begin
                lat = c + 1;
                break;
            end
        end
        @(negedge wb_clk_i);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    endtask

    vec_t        vecs[15];
    logic [15:0] rd;
    int          lat;
    int          edges;
    logic [7:0]  bits;
    bit          sp_ok;
    bit          r_ok;
    logic [3:0]  ack_pat;
    logic        sclk0;
    bit          quiet;

    initial begin
        vecs[0]  = '{2'd1, 16'h0000, 1'b0, 2'b11, 16'h0301, 8'hFF};
        vecs[1]  = '{2'd3, 16'h0000, 1'b0, 2'b11, 16'h0000, 8'hFF};
        vecs[2]  = '{2'd0, 16'h0000, 1'b0, 2'b11, 16'h0000, 8'hFF};
        vecs[3]  = '{2'd2, 16'h0000, 1'b0, 2'b11, 16'h00FF, 8'hFF};
        vecs[4]  = '{2'd1, 16'h07FF, 1'b1, 2'b01, 16'h0000, 8'hFF};
        vecs[5]  = '{2'd1, 16'h0000, 1'b0, 2'b11, 16'h0301, 8'hFF};
        vecs[6]  = '{2'd1, 16'hFF85, 1'b1, 2'b11, 16'h0000, 8'hFF};
        vecs[7]  = '{2'd1, 16'h0000, 1'b0, 2'b11, 16'h0785, 8'hFF};
        vecs[8]  = '{2'd3, 16'hFFFF, 1'b1, 2'b11, 16'h0000, 8'hFF};
        vecs[9]  = '{2'd3, 16'h0000, 1'b0, 2'b11, 16'h0000, 8'hFF};
        vecs[10] = '{2'd2, 16'h12FE, 1'b1, 2'b10, 16'h0000, 8'hFF};
        vecs[11] = '{2'd2, 16'hABFE, 1'b1, 2'b01, 16'h0000, 8'hFE};
        vecs[12] = '{2'd2, 16'h0000, 1'b0, 2'b11, 16'h00FE, 8'hFE};
        vecs[13] = '{2'd1, 16'h0301, 1'b1, 2'b11, 16'h0000, 8'hFE};
        vecs[14] = '{2'd1, 16'h0000, 1'b0, 2'b11, 16'h0301, 8'hFE};

        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1;
        check("rst_sclk", sclk, 1'b1);
        check("rst_mosi", mosi, 1'b1);
        check("rst_ss", ss, 8'hFF);
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_dat_o", wb_dat_o, 16'h0000);

        for (int i = 0; i < 15; i++) begin
            wb_access(vecs[i].adr, vecs[i].dat, vecs[i].we, vecs[i].sel, rd, lat);
            check($sformatf("vec%0d_lat", i), lat, 1);
            if (!vecs[i].we) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_ss", i), ss, vecs[i].exp_ss);
        end

        // Held request: ack pulses must never be back-to-back.
        @(negedge wb_clk_i);
        wb_adr_i = 2'd1; wb_we_i = 1'b0; wb_sel_i = 2'b11; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge wb_clk_i); #1;
            ack_pat[c] = wb_ack_o;
        end
        @(negedge wb_clk_i);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        check("ack_no_b2b", ack_pat, 4'b0101);
        @(posedge wb_clk_i); #1;
        check("ack_one_cycle", wb_ack_o, 1'b0);

        // Mode 3, DIV=1, loopback, 0xA5.
        tie_mode = 1'b0;
        xfer(8'hA5, 1, 1'b1, 0, 0, lat, edges, bits, sp_ok, r_ok);
        check("m3_lat", lat, 34);
        check("m3_edges", edges, 16);
        check("m3_spacing", sp_ok, 1'b1);
        check("m3_mosi", bits, 8'hA5);
        check("m3_idle_sclk", sclk, 1'b1);
        check("m3_idle_mosi", mosi, 1'b1);
        wb_access(2'd0, 16'h0000, 1'b0, 2'b11, rd, lat);
        check("m3_rx", rd, 16'h00A5);

        // Mode 0, DIV=0, LSB first, miso tied high, 0x01.
        wb_access(2'd1, 16'h0400, 1'b1, 2'b11, rd, lat);
        @(posedge wb_clk_i); #1;
        check("m0_idle_sclk", sclk, 1'b0);
        tie_mode = 1'b1; tie_val = 1'b1;
        xfer(8'h01, 0, 1'b0, 0, 0, lat, edges, bits, sp_ok, r_ok);
        check("m0_lat", lat, 18);
        check("m0_edges", edges, 16);
        check("m0_spacing", sp_ok, 1'b1);
        check("m0_mosi", bits, 8'h80);
        check("m0_idle_mosi", mosi, 1'b1);
        wb_access(2'd0, 16'h0000, 1'b0, 2'b11, rd, lat);
        check("m0_rx", rd, 16'h00FF);

        // DATA write with sel=10: plain ack, no serial activity.
        sclk0 = sclk;
        wb_access(2'd0, 16'h0055, 1'b1, 2'b10, rd, lat);
        check("nosel_lat", lat, 1);
        quiet = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge wb_clk_i); #1;
            if (sclk !== sclk0) quiet = 1'b0;
        end
        check("nosel_quiet", quiet, 1'b1);
        wb_access(2'd3, 16'h0000, 1'b0, 2'b11, rd, lat);
        check("nosel_busy", rd, 16'h0000);

        // Bus dropped mid-byte: byte completes, no ack, rx updated.
        wb_access(2'd1, 16'h0301, 1'b1, 2'b11, rd, lat);
        tie_mode = 1'b0;
        xfer(8'h3C, 1, 1'b1, 5, 0, lat, edges, bits, sp_ok, r_ok);
        check("drop_no_ack", lat, -1);
        check("drop_edges", edges, 16);
        wb_access(2'd0, 16'h0000, 1'b0, 2'b11, rd, lat);
        check("drop_rx", rd, 16'h003C);

        // Reset at edge 7 aborts the byte.
        xfer(8'hFF, 1, 1'b1, 0, 7, lat, edges, bits, sp_ok, r_ok);
        check("rstx_outputs", r_ok, 1'b1);
        check("rstx_no_ack", lat, -1);
        check("rstx_edges", edges, 7);
        check("rstx_ss", ss, 8'hFF);
        wb_access(2'd3, 16'h0000, 1'b0, 2'b11, rd, lat);
        check("rstx_busy", rd, 16'h0000);
        wb_access(2'd1, 16'h0000, 1'b0, 2'b11, rd, lat);
        check("rstx_ctrl", rd, 16'h0301);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 Parameter: NUM_SS, default 8, number of active-low slave selects (legal 1..16).
REQ-002 Parameter: DIV_RST, default 8'd1, reset value of CTRL.DIV.
REQ-003 Port: wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 Port: wb_rst_i  in  1  synchronous, active-high reset.
REQ-005 Port: wb_adr_i  in  2  register select (0 DATA, 1 CTRL, 2 SS, 3 STATUS).
REQ-006 Port: wb_dat_i  in  16  write data.
REQ-007 Port: wb_dat_o  out  16  read data, registered.
REQ-008 Port: wb_we_i  in  1  write enable.
REQ-009 Port: wb_sel_i  in  2  byte lanes.
REQ-010 Port: wb_stb_i, wb_cyc_i  in  1 each  strobe and cycle; request = stb & cyc.
REQ-011 Port: wb_ack_o  out  1  single-cycle acknowledge.
REQ-012 Port: sclk  out  1  serial clock.
REQ-013 Port: miso  in  1  serial data in.
REQ-014 Port: mosi  out  1  serial data out.
REQ-015 Port: ss  out  NUM_SS  slave selects, active low, direct from SS register.

Function
REQ-016 CTRL SHALL hold DIV[7:0], CPOL[8], CPHA[9], LSBF[10]; write needs sel=2'b11; reads return zero in unused bits.
REQ-017 SS register SHALL be written from wb_dat_i[NUM_SS-1:0] when sel[0] (and sel[1] if NUM_SS>8).
REQ-018 STATUS[0] SHALL read busy; STATUS is read-only, writes acked and ignored.
REQ-019 Non-DATA-write accesses SHALL ack one cycle after request is sampled, ack held high exactly one cycle, no back-to-back ack.
REQ-020 State machine SHALL have IDLE, XFER, DONE.
REQ-021 IDLE -> XFER on request & we & adr=0 & sel[0]; tx byte wb_dat_i[7:0] latched, edge counter=0, divider loaded with DIV.
REQ-022 DATA write with sel[0]=0 SHALL ack in one cycle without starting a transfer.
REQ-023 In XFER, one sclk edge SHALL occur each time divider reaches 0 (reloaded with DIV), giving half-period DIV+1 cycles; exactly 16 edges per byte.
REQ-024 sclk SHALL idle at CPOL; first edge toggles away from CPOL.
REQ-025 CPHA=0: first data bit on mosi at XFER entry; sample miso on odd edges, shift mosi on even edges except edge 16.
REQ-026 CPHA=1: shift mosi on odd edges (first bit on edge 1), sample miso on even edges.
REQ-027 LSBF=0 SHALL send/receive MSB first; LSBF=1 LSB first.
REQ-028 After edge 16: XFER -> DONE; rx byte written to DATA read register; DONE -> IDLE next cycle with wb_ack_o=1 that cycle.
REQ-029 Total DATA-write latency SHALL be 16*(DIV+1)+2 cycles request-sampled to ack.
REQ-030 If request drops during XFER, transfer SHALL complete, rx byte updated, ack suppressed.
REQ-031 DATA read SHALL return {8'h00, rx byte} with one-cycle ack; in XFER reads return last completed byte.
REQ-032 CTRL/SS writes during XFER SHALL update registers on ack but DIV/CPOL/CPHA/LSBF are latched at XFER entry and unaffected mid-byte.
REQ-033 mosi SHALL return to 1 in IDLE.
REQ-034 DIV=0 SHALL be legal (sclk = wb_clk_i/2).

Reset
REQ-035 On wb_rst_i: state IDLE, CTRL={LSBF 0, CPHA 1, CPOL 1, DIV DIV_RST}, ss all ones, sclk 1, mosi 1, wb_ack_o 0, wb_dat_o 0, rx byte 0, busy 0.
REQ-036 Reset during XFER SHALL abort with no ack and outputs at reset values the next cycle.

Verification
REQ-037 Reset defaults: after reset read CTRL -> 16'h0301 (DIV_RST=1), STATUS -> 0, ss=8'hFF, sclk=1.
REQ-038 Mode 3, DIV=1, miso loopback, write DATA 8'hA5 -> 16 edges each 2 cycles, mosi sequence 10100101, ack at cycle 34, read DATA 16'h00A5.
REQ-039 Mode 0, DIV=0, LSBF=1, write 8'h01, miso tied 1 -> sclk idles 0, mosi first bit 1 then 0s, rx 8'hFF, ack at cycle 18.
REQ-040 Write SS 8'hFE -> ss=8'hFE next cycle; write DATA with sel=2'b10 -> one-cycle ack, no sclk activity.
REQ-041 Drop cyc mid-byte -> sclk completes 16 edges, no ack, next DATA read returns new rx byte.
REQ-042 Assert wb_rst_i at edge 7 of transfer -> next cycle sclk=1, mosi=1, busy=0, no ack ever issued.
